// File: rtl/my_serdes_rx.sv
// my_serdes_rx: acquires lock on idle runs, strips idles, and buffers payload words in a first-word-fall-through FIFO
module my_serdes_rx #(
  parameter int FIFOSIZE   = 8,
  parameter int CNTR_WIDTH = 3,
  parameter int LOCK_IDLES = 16
) (
  input  logic        dsp_clk,
  input  logic        dsp_rst_n,
  input  logic [15:0] ser_r,
  input  logic        ser_rklsb,
  input  logic        ser_rkmsb,
  input  logic        ser_rx_err,
  output logic [15:0] rx_dat_o,
  output logic        rx_klsb_o,
  output logic        rx_kmsb_o,
  output logic        rx_rdy,
  input  logic        rx_en,
  output logic        rx_locked,
  output logic        rx_ovf,
  input  logic        rx_ovf_clr
);
  logic [15:0] s_dat;
  logic s_kl, s_km, s_err, s_vld;
  logic is_idle, enq, deq, wr, drop, full, locked_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [CNTR_WIDTH-1:0] wp, rp, wp_inc;
  logic [17:0] mem [FIFOSIZE];
  always_ff @(posedge dsp_clk or negedge dsp_rst_n)
    if (!dsp_rst_n) begin
      s_dat <= '0;
      s_kl  <= 1'b0;
      s_km  <= 1'b0;
      s_err <= 1'b0;
      s_vld <= 1'b0;
    end else begin
      s_dat <= ser_r;
      s_kl  <= ser_rklsb;
      s_km  <= ser_rkmsb;
      s_err <= ser_rx_err;
      s_vld <= 1'b1;
    end
  assign is_idle = s_vld && s_kl && s_km && s_dat == 16'h3C3C;
  always_ff @(posedge dsp_clk or negedge dsp_rst_n)
    if (!dsp_rst_n) begin
      rx_locked <= 1'b0;
      cnt       <= '0;
    end else begin
      rx_locked <= locked_nxt;
      cnt       <= cnt_nxt;
    end
  // The final idle of the run declares lock on the same edge it is counted.
  always_comb begin
    locked_nxt = rx_locked;
    cnt_nxt    = cnt;
    if (s_vld && rx_locked) locked_nxt = !s_err;
    else if (s_vld && (s_err || !is_idle)) cnt_nxt = '0;
    else if (s_vld && cnt == 8'(LOCK_IDLES - 1)) begin
      locked_nxt = 1'b1;
      cnt_nxt    = '0;
    end else if (s_vld) cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  end
  always_comb enq = rx_locked && s_vld && !s_err && !is_idle;
  assign rx_rdy = (wp != rp) || full;
  assign deq    = rx_en && rx_rdy;
  assign wr     = enq && (!full || deq);
  assign drop   = enq && full && !deq;
  assign wp_inc = wp + 1'b1;
  always_ff @(posedge dsp_clk)
    if (wr) mem[wp] <= {s_km, s_kl, s_dat};
  always_ff @(posedge dsp_clk or negedge dsp_rst_n)
    if (!dsp_rst_n) begin
      wp     <= '0;
      rp     <= '0;
      full   <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr) wp <= wp_inc;
      if (deq) rp <= rp + 1'b1;
      if (wr != deq) full <= wr && wp_inc == rp;
      rx_ovf <= drop ? 1'b1 : (rx_ovf_clr ? 1'b0 : rx_ovf);
    end
  assign {rx_kmsb_o, rx_klsb_o, rx_dat_o} = rx_rdy ? mem[rp] : 18'h0;
endmodule

// File: tb/tb_my_serdes_rx.sv
// tb_my_serdes_rx: directed scoreboard bench for the SERDES receive path
module tb_my_serdes_rx;
  logic        dsp_clk = 1'b0, dsp_rst_n = 1'b0;
  logic [15:0] ser_r = '0;
  logic        ser_rklsb = 1'b0, ser_rkmsb = 1'b0, ser_rx_err = 1'b0;
  logic        rx_en = 1'b0, rx_ovf_clr = 1'b0;
  logic [15:0] rx_dat_o;
  logic        rx_klsb_o, rx_kmsb_o, rx_rdy, rx_locked, rx_ovf;
  logic [17:0] q[$];
  int checks = 0, failures = 0;

  my_serdes_rx dut (
    .dsp_clk(dsp_clk), .dsp_rst_n(dsp_rst_n), .ser_r(ser_r), .ser_rklsb(ser_rklsb),
    .ser_rkmsb(ser_rkmsb), .ser_rx_err(ser_rx_err), .rx_dat_o(rx_dat_o), .rx_klsb_o(rx_klsb_o),
    .rx_kmsb_o(rx_kmsb_o), .rx_rdy(rx_rdy), .rx_en(rx_en), .rx_locked(rx_locked),
    .rx_ovf(rx_ovf), .rx_ovf_clr(rx_ovf_clr)
  );

  always #5 dsp_clk = ~dsp_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic kl, input logic km, input logic e);
    ser_r = d;
    ser_rklsb = kl;
    ser_rkmsb = km;
    ser_rx_err = e;
    tick();
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) drive(16'h3C3C, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pay(input logic [15:0] d, input logic kl, input logic km, input logic keep);
    if (keep) q.push_back({km, kl, d});
    drive(d, kl, km, 1'b0);
  endtask

  task automatic deq_check(input string tag);
    chk(tag, {14'h0, rx_kmsb_o, rx_klsb_o, rx_dat_o}, {14'h0, q[0]});
    rx_en = 1'b1;
    tick();
    rx_en = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    // T1: reset state and lock acquisition
    #2;
    chk("rst_rdy", 32'(rx_rdy), 32'h0);
    chk("rst_locked", 32'(rx_locked), 32'h0);
    chk("rst_dat", 32'({rx_kmsb_o, rx_klsb_o, rx_dat_o}), 32'h0);
    tick();
    dsp_rst_n = 1'b1;
    idles(16);
    chk("lock_after_15", 32'(rx_locked), 32'h0);
    idles(1);
    chk("lock_after_16", 32'(rx_locked), 32'h1);
    chk("lock_rdy", 32'(rx_rdy), 32'h0);
    // T2: single payload latency, K-flagged non-idles pass through
    pay(16'h1234, 1'b0, 1'b0, 1'b1);
    chk("t2_rdy_1cyc", 32'(rx_rdy), 32'h0);
    idles(1);
    chk("t2_rdy_2cyc", 32'(rx_rdy), 32'h1);
    deq_check("t2_head");
    chk("t2_rdy_drained", 32'(rx_rdy), 32'h0);
    pay(16'hBC3C, 1'b1, 1'b1, 1'b1);
    pay(16'h3C3C, 1'b1, 1'b0, 1'b1);
    idles(3);
    deq_check("t2_kword0");
    deq_check("t2_kword1");
    chk("t2_no_idles", 32'(rx_rdy), 32'h0);
    // T3: overflow on the ninth word, sticky flag, in-order drain
    for (int i = 1; i <= 9; i++) pay(16'(i), 1'b0, 1'b0, i <= 8);
    idles(2);
    chk("t3_ovf", 32'(rx_ovf), 32'h1);
    rx_ovf_clr = 1'b1;
    tick();
    rx_ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(rx_ovf), 32'h0);
    for (int i = 0; i < 8; i++) deq_check("t3_drain");
    chk("t3_empty", 32'(rx_rdy), 32'h0);
    // T4: streaming through a full FIFO with simultaneous enq+deq
    for (int i = 0; i < 8; i++) pay(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b1);
    idles(1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_stream", {14'h0, rx_kmsb_o, rx_klsb_o, rx_dat_o}, {14'h0, q[0]});
      rx_en = (i > 0);
      pay(16'h0200 + 16'(i), 1'b0, 1'b1, 1'b1);
      if (rx_en) void'(q.pop_front());
    end
    rx_en = 1'b0;
    ser_r = 16'h3C3C; ser_rklsb = 1'b1; ser_rkmsb = 1'b1;
    while (q.size() > 0) deq_check("t4_tail");
    chk("t4_ovf", 32'(rx_ovf), 32'h0);
    chk("t4_empty", 32'(rx_rdy), 32'h0);
    // T5: error drops lock, erroneous word discarded, earlier words kept
    pay(16'hA001, 1'b0, 1'b0, 1'b1);
    pay(16'hA002, 1'b0, 1'b0, 1'b1);
    drive(16'hBEEF, 1'b0, 1'b0, 1'b1);
    idles(1);
    chk("t5_unlock", 32'(rx_locked), 32'h0);
    pay(16'h5555, 1'b0, 1'b0, 1'b0);
    idles(1);
    deq_check("t5_drain");
    deq_check("t5_drain");
    chk("t5_no_beef", 32'(rx_rdy), 32'h0);
    pay(16'h6666, 1'b0, 1'b0, 1'b0);
    idles(16);
    chk("t5_relock_15", 32'(rx_locked), 32'h0);
    idles(1);
    chk("t5_relock_16", 32'(rx_locked), 32'h1);
    chk("t5_unlocked_discard", 32'(rx_rdy), 32'h0);
    // T6: asynchronous reset mid-stream
    pay(16'h7777, 1'b0, 1'b0, 1'b1);
    pay(16'h7778, 1'b0, 1'b0, 1'b1);
    idles(1);
    chk("t6_pre_rdy", 32'(rx_rdy), 32'h1);
    #3 dsp_rst_n = 1'b0;
    #1;
    q.delete();
    chk("t6_rdy", 32'(rx_rdy), 32'h0);
    chk("t6_dat", 32'({rx_kmsb_o, rx_klsb_o, rx_dat_o}), 32'h0);
    chk("t6_locked", 32'(rx_locked), 32'h0);
    tick();
    dsp_rst_n = 1'b1;
    idles(10);
    chk("t6_no_relock", 32'(rx_locked), 32'h0);
    chk("t6_empty", 32'(rx_rdy), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
